load_store_unit: RTL

- Initiator side of the data-memory port; sits between the microcoded core and `memory`.
- Turns RISC-V LB/LH/LW/LBU/LHU/SB/SH/SW requests into word-wide accesses on the memory port.
- Memory is word-only with registered address and registered output, so sub-word stores are done as read-modify-write.
- Loads are lane-extracted and sign/zero-extended; misaligned accesses are flagged and no memory access is made.

---
 rtl/mem_pkg.sv | 29 ++
 rtl/lsu_lane_unit.sv | 42 ++++
 rtl/load_store_unit.sv | 126 ++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared funct3 codes, FSM state type and the access legality check for the load/store unit.
// Declarations only: no state, no latency, no flow control.
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {IDLE, RD_WAIT, WRITE, DONE} lsu_state_t;

  // Unsigned sub-word codes have no store form, so they are illegal for writes.
  function automatic logic is_misaligned(input logic [2:0] funct3, input logic write,
                                         input logic [1:0] addr_lo);
    logic bad;
    bad = 1'b1;
    case (funct3)
      F3_B:    bad = 1'b0;
      F3_H:    bad = addr_lo[0];
      F3_W:    bad = (addr_lo != 2'b00);
      F3_BU:   bad = write;
      F3_HU:   bad = write | addr_lo[0];
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_lane_unit.sv
// Byte-lane steering shared by the load extract path and the store merge path.
// Purely combinational (zero latency); no flow control.
module lsu_lane_unit
  import mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  input  logic [31:0] wdata,
  output logic [31:0] load_val,
  output logic [31:0] store_word
);

  logic [4:0]  byte_sh;
  logic [4:0]  half_sh;
  logic [31:0] shifted;

  assign byte_sh = {offset, 3'b000};
  assign half_sh = {offset[1], 4'b0000};
  assign shifted = rdata >> byte_sh;

  always_comb begin
    load_val = rdata;
    case (funct3)
      F3_B:    load_val = {{24{shifted[7]}}, shifted[7:0]};
      F3_BU:   load_val = {24'd0, shifted[7:0]};
      F3_H:    load_val = {{16{shifted[15]}}, shifted[15:0]};
      F3_HU:   load_val = {16'd0, shifted[15:0]};
      default: load_val = rdata;
    endcase
  end

  always_comb begin
    store_word = wdata;
    case (funct3)
      F3_B:    store_word = (rdata & ~(32'h0000_00FF << byte_sh)) | ({24'd0, wdata[7:0]} << byte_sh);
      F3_H:    store_word = (rdata & ~(32'h0000_FFFF << half_sh)) | ({16'd0, wdata[15:0]} << half_sh);
      default: store_word = wdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Word-memory initiator for RISC-V byte/half/word loads and stores; sub-word stores are read-modify-write.
// Load done at READ_LATENCY+2, SW at 2, SB/SH at READ_LATENCY+3, errors at 1; requests while busy are dropped, clk_enable freezes all state.
module load_store_unit
  import mem_pkg::*;
#(
  parameter int READ_LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clk_enable,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        busy,
  output logic        done,
  output logic        misaligned,
  output logic [31:0] load_data,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  input  logic [31:0] mem_rdata
);

  localparam int CW = (READ_LATENCY < 1) ? 1 : $clog2(READ_LATENCY + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(READ_LATENCY);

  lsu_state_t    state;
  logic [CW-1:0] cnt;
  logic [1:0]    offset;
  logic [2:0]    funct3_q;
  logic          write_q;
  logic [31:0]   wdata_q;
  logic          we_q;
  logic [31:0]   load_val;
  logic [31:0]   store_word;

  lsu_lane_unit u_lane (
    .rdata      (mem_rdata),
    .offset     (offset),
    .funct3     (funct3_q),
    .wdata      (wdata_q),
    .load_val   (load_val),
    .store_word (store_word)
  );

  // A frozen or resetting cycle must never write, even if WRITE is pending.
  assign mem_we = we_q & ~rst & clk_enable;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      offset     <= '0;
      funct3_q   <= '0;
      write_q    <= 1'b0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      misaligned <= 1'b0;
      load_data  <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else if (clk_enable) begin
      done <= 1'b0;
      we_q <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            mem_addr <= {req_addr[31:2], 2'b00};
            offset   <= req_addr[1:0];
            funct3_q <= req_funct3;
            write_q  <= req_write;
            wdata_q  <= req_wdata;
            cnt      <= '0;
            busy     <= 1'b1;
            if (is_misaligned(req_funct3, req_write, req_addr[1:0])) begin
              state      <= DONE;
              done       <= 1'b1;
              misaligned <= 1'b1;
            end else if (req_write && (req_funct3 == F3_W)) begin
              state     <= WRITE;
              we_q      <= 1'b1;
              mem_wdata <= req_wdata;
            end else begin
              state <= RD_WAIT;
            end
          end
        end
        RD_WAIT: begin
          // Address was registered on acceptance; memory adds READ_LATENCY edges after that.
          if (cnt == CNT_LAST) begin
            if (write_q) begin
              state     <= WRITE;
              we_q      <= 1'b1;
              mem_wdata <= store_word;
            end else begin
              state      <= DONE;
              done       <= 1'b1;
              misaligned <= 1'b0;
              load_data  <= load_val;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        WRITE: begin
          state      <= DONE;
          done       <= 1'b1;
          misaligned <= 1'b0;
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
